alu_lockstep_sched: RTL and testbench
=====================================

// Module: alu_lockstep_sched
// PURPOSE
//  Round-robin scheduler that shares the duplicated 4-bit ALU pair (alu_xor_4) between two requesters.
//  Each accepted op is issued identically to both ALU lanes (lockstep).
//  After the ALU latency, the block samples the lane-1 result and the lane-compare outputs (x, y).
//  It returns one tagged response and keeps a saturating mismatch counter plus a sticky fault flag.
//  Sits between the io/wishbone-side request logic and u_alu_xor_4 in the user project.
// PARAMETERS
//  ALU_LAT  1  ALU clock-to-result latency in cycles (0 = combinational ALU); legal range 0..7
//  CNT_W    8  mismatch counter width
// PORTS
//  wb_clk_i    in   1      clock
//  wb_rst_ni   in   1      async reset, active low
//  req0_valid  in   1      requester 0 op valid; held until req0_ready
//  req0_ready  out  1      requester 0 op accepted this cycle
//  req0_a      in   4      operand A
//  req0_b      in   4      operand B
//  req0_sel    in   2      ALU select
//  req1_*      -    -      same set as req0_* for requester 1
//  alu_a0/alu_a1    out  4  operand A to lane 1 / lane 2 (always equal)
//  alu_b0/alu_b1    out  4  operand B to lane 1 / lane 2 (always equal)
//  alu_sel1/alu_sel2 out 2  select to lane 1 / lane 2 (always equal)
//  alu_out1    in   4      lane-1 ALU result
//  alu_carry1  in   1      lane-1 carry
//  alu_x       in   4      bitwise XOR of lane results; nonzero = mismatch
//  alu_y       in   1      XOR of lane carries; 1 = mismatch
//  rsp_valid   out  1      response valid; held until rsp_ready
//  rsp_ready   in   1      response consumed
//  rsp_id      out  1      index of the requester that owns the response
//  rsp_data    out  4      captured alu_out1
//  rsp_carry   out  1      captured alu_carry1
//  rsp_err     out  1      captured (alu_x != 0) | alu_y
//  err_cnt     out  CNT_W  count of erroneous ops; saturates at all-ones
//  fault       out  1      sticky; set by any erroneous op
//  fault_clr   in   1      synchronous clear of fault and err_cnt
// BEHAVIOUR
//  Reset (async, wb_rst_ni=0):
//   - state=IDLE; all outputs 0; last_grant=1, so req0 wins the first contention.
//   - An in-flight op or pending response is discarded.
//   - reqN_ready=0 while in reset.
//  FSM states IDLE -> WAIT -> RESP -> IDLE; at most one op in flight.
//  IDLE:
//   - grant = the valid requester; if both are valid, grant = !last_grant.
//   - reqN_ready = (state==IDLE) & (grant==N), combinational; never both high.
//   - On accept (cycle T): latch a/b/sel into the alu_* regs, rsp_id<=grant, last_grant<=grant, go to WAIT.
//  WAIT:
//   - Lasts ALU_LAT+1 cycles (T+1..T+1+ALU_LAT), counted by a 3-bit down counter.
//   - At the end of the last WAIT cycle, capture rsp_data, rsp_carry and rsp_err; go to RESP.
//  RESP:
//   - rsp_valid=1 from cycle T+2+ALU_LAT, so a response appears T+3 after accept when ALU_LAT=1.
//   - rsp_valid and rsp_* are stable until the cycle where rsp_ready=1; go to IDLE on the next edge.
//   - A new accept is possible in the cycle after the handshake.
//   - Back-to-back throughput is one op per ALU_LAT+3 cycles.
//  Operand regs hold their value after an op until the next accept; lanes are never driven differently.
//  Error bookkeeping:
//   - On capture with rsp_err=1: fault<=1 and err_cnt<=err_cnt+1, unless err_cnt is all-ones (saturate).
//   - fault_clr=1: fault<=0 and err_cnt<=0.
//   - fault_clr in the same cycle as an erroneous capture: fault<=1 and err_cnt<=1 (set wins).
//  A requester deasserting valid before ready is illegal and unsupported; no ready is given to invalid requests.
// TESTING
//  1. Single op: req0 a=4'h9 b=4'h8 sel=00 (add), ALU_LAT=1.
//     -> req0_ready at T; rsp_valid at T+3 with rsp_id=0, data=4'h1, carry=1, err=0.
//  2. Fairness: req0 and req1 held valid continuously for 6 ops.
//     -> grants alternate 0,1,0,1,0,1; responses arrive in grant order with matching rsp_id.
//  3. Backpressure: rsp_ready=0 for 5 cycles.
//     -> rsp_* stable throughout; req0_ready and req1_ready stay 0 until the handshake.
//  4. Lane fault: bench model forces alu_x=4'h2 on one op.
//     -> rsp_err=1, fault=1, err_cnt=1; next clean op leaves fault=1 and err_cnt=1.
//  5. Saturation and clear (CNT_W=2): 5 faulty ops -> err_cnt=3.
//     -> fault_clr pulsed alone gives err_cnt=0 and fault=0.
//     -> fault_clr pulsed with a faulty capture gives err_cnt=1 and fault=1.
//  6. Reset mid-WAIT: wb_rst_ni low for 1 cycle.
//     -> all outputs 0 immediately, no response emitted, and req0 is granted first afterwards.

Source files
------------

// File: rtl/alu_lockstep_sched.sv
// ---------------------------------------------------------------------------
// alu_lockstep_sched
//
// Purpose:
//   Round-robin scheduler that shares a duplicated (lockstep) 4-bit ALU pair
//   between two requesters. An accepted op is driven identically onto both
//   ALU lanes. After the ALU latency the lane-1 result and the lane-compare
//   outputs are captured into a single tagged response. Erroneous ops bump a
//   saturating mismatch counter and set a sticky fault flag.
//
// Handshakes:
//   reqN_valid/reqN_ready : an op transfers on a clock edge where both are 1.
//                           The requester holds valid and operands until
//                           ready; ready is only ever given to a valid
//                           requester, and never to both at once.
//   rsp_valid/rsp_ready   : a response transfers on a clock edge where both
//                           are 1. rsp_valid and rsp_* are held stable until
//                           that edge.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   req0_*/req1_*                valid/ready/a/b/sel per requester
//   alu_a0/a1, alu_b0/b1,        operands and select to the two ALU lanes
//   alu_sel1/sel2                (always equal)
//   alu_out1, alu_carry1         lane-1 result and carry
//   alu_x, alu_y                 lane-compare: XOR of results / of carries
//   rsp_valid/ready/id/data/     tagged response
//   carry/err
//   err_cnt, fault, fault_clr    saturating error counter, sticky fault, clear
//   dbg_state                    current FSM state (IDLE=0, WAIT=1, RESP=2)
// ---------------------------------------------------------------------------
module alu_lockstep_sched #(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [1:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [1:0]       req1_sel,
    output logic [3:0]       alu_a0,
    output logic [3:0]       alu_a1,
    output logic [3:0]       alu_b0,
    output logic [3:0]       alu_b1,
    output logic [1:0]       alu_sel1,
    output logic [1:0]       alu_sel2,
    input  logic [3:0]       alu_out1,
    input  logic             alu_carry1,
    input  logic [3:0]       alu_x,
    input  logic             alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault,
    input  logic             fault_clr,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // WAIT lasts ALU_LAT+1 cycles: the counter is loaded with ALU_LAT and the
    // capture happens in the cycle where it reads zero.
    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

    logic [1:0]       state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic [2:0]       wait_cnt_q,   wait_cnt_d;
    logic [3:0]       op_a_q,       op_a_d;
    logic [3:0]       op_b_q,       op_b_d;
    logic [1:0]       op_sel_q,     op_sel_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [3:0]       rsp_data_q,   rsp_data_d;
    logic             rsp_carry_q,  rsp_carry_d;
    logic             rsp_err_q,    rsp_err_d;
    logic [CNT_W-1:0] err_cnt_q,    err_cnt_d;
    logic             fault_q,      fault_d;

    logic grant;
    logic accept;
    logic capture;
    logic cap_err;

    always_comb begin
        // With both requesters valid the one not served last wins; otherwise
        // the single valid requester (req1_valid picks 1, else 0).
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        // Gating with the reset keeps ready low while reset is held, even
        // though state_q already reads IDLE.
        accept  = wb_rst_ni && (state_q == ST_IDLE) && (req0_valid || req1_valid);
        capture = (state_q == ST_WAIT) && (wait_cnt_q == 3'd0);
        cap_err = (alu_x != 4'd0) || alu_y;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sel_d     = op_sel_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        err_cnt_d    = err_cnt_q;
        fault_d      = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_a_d       = grant ? req1_a   : req0_a;
                    op_b_d       = grant ? req1_b   : req0_b;
                    op_sel_d     = grant ? req1_sel : req0_sel;
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    wait_cnt_d   = LAT_INIT;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (capture) begin
                    rsp_data_d  = alu_out1;
                    rsp_carry_d = alu_carry1;
                    rsp_err_d   = cap_err;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An erroneous capture takes priority over a simultaneous clear: the
        // clear wipes history, then this op counts as the first error.
        if (capture && cap_err) begin
            fault_d = 1'b1;
            if (fault_clr) begin
                err_cnt_d = CNT_W'(1);
            end else if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end else if (fault_clr) begin
            fault_d   = 1'b0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= 3'd0;
            op_a_q       <= 4'd0;
            op_b_q       <= 4'd0;
            op_sel_q     <= 2'd0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= 4'd0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            err_cnt_q    <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sel_q     <= op_sel_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
            err_cnt_q    <= err_cnt_d;
            fault_q      <= fault_d;
        end
    end

    // Both lanes are fed from the same registers so they can never diverge.
    assign alu_a0     = op_a_q;
    assign alu_a1     = op_a_q;
    assign alu_b0     = op_b_q;
    assign alu_b1     = op_b_q;
    assign alu_sel1   = op_sel_q;
    assign alu_sel2   = op_sel_q;

    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_err    = rsp_err_q;
    assign err_cnt    = err_cnt_q;
    assign fault      = fault_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_lockstep_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_lockstep_sched
//
// Bench for alu_lockstep_sched (ALU_LAT=1, CNT_W=2). A registered lockstep
// ALU pair is modelled here; lane 2 can be corrupted per op. Accepted ops
// push an expected response into exp_q; a negedge monitor pops and compares
// on each response handshake, and also checks arbitration, latency,
// backpressure stability and the error bookkeeping.
// ---------------------------------------------------------------------------
module tb_alu_lockstep_sched;

    localparam int ALU_LAT = 1;
    localparam int CNT_W   = 2;

    logic             wb_clk_i;
    logic             wb_rst_ni;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_a, req0_b, req1_a, req1_b;
    logic [1:0]       req0_sel, req1_sel;
    logic [3:0]       alu_a0, alu_a1, alu_b0, alu_b1;
    logic [1:0]       alu_sel1, alu_sel2;
    logic [3:0]       alu_out1, alu_x;
    logic             alu_carry1, alu_y;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
    logic [3:0]       rsp_data;
    logic [CNT_W-1:0] err_cnt;
    logic             fault, fault_clr;
    logic [1:0]       dbg_state;

    alu_lockstep_sched #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .alu_a0     (alu_a0),
        .alu_a1     (alu_a1),
        .alu_b0     (alu_b0),
        .alu_b1     (alu_b1),
        .alu_sel1   (alu_sel1),
        .alu_sel2   (alu_sel2),
        .alu_out1   (alu_out1),
        .alu_carry1 (alu_carry1),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err),
        .err_cnt    (err_cnt),
        .fault      (fault),
        .fault_clr  (fault_clr),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // packed expected entry: [22:7] accept cycle, [6] err, [5] carry,
    // [4:1] data, [0] id
    logic [22:0] exp_q[$];

    logic       inj0, inj1, flight_inj;
    logic       model_last;
    int         model_cnt;
    logic       model_fault;
    logic       after_rst;
    logic       rand_ready, bp_hold;

    logic       prev_valid, prev_ready;
    logic [6:0] prev_rsp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU: 00 add, 01 subtract (borrow in carry), 10 and, 11 xor.
    function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] s);
        case (s)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    // ---------------- lockstep ALU pair (1-cycle latency) ----------------
    logic [3:0] lane2_out;
    logic       lane2_carry;
    logic [4:0] r1, r2;
    always @(posedge wb_clk_i) begin
        r1 = ref_alu(alu_a0, alu_b0, alu_sel1);
        r2 = ref_alu(alu_a1, alu_b1, alu_sel2) ^ (flight_inj ? 5'h02 : 5'h00);
        alu_out1    <= r1[3:0];
        alu_carry1  <= r1[4];
        lane2_out   <= r2[3:0];
        lane2_carry <= r2[4];
    end
    assign alu_x = alu_out1 ^ lane2_out;
    assign alu_y = alu_carry1 ^ lane2_carry;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge wb_clk_i) begin
        logic        id;
        logic [4:0]  res;
        logic        inj;
        logic [22:0] e;
        if (!wb_rst_ni) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            // accept side: this cycle's valid&ready transfers on the next edge
            if (req0_ready || req1_ready) begin
                check("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
                id = req1_ready;
                check("ready_to_valid", {31'd0, id ? req1_valid : req0_valid}, 32'd1);
                if (req0_valid && req1_valid)
                    check("rr_grant", {31'd0, id}, {31'd0, ~model_last});
                if (after_rst) begin
                    check("first_grant_after_reset", {31'd0, id}, 32'd0);
                    after_rst = 1'b0;
                end
                model_last = id;
                res = id ? ref_alu(req1_a, req1_b, req1_sel) : ref_alu(req0_a, req0_b, req0_sel);
                inj = id ? inj1 : inj0;
                flight_inj = inj;
                exp_q.push_back({cyc[15:0], inj, res[4], res[3:0], id});
            end

            // response side
            if (rsp_valid) begin
                check("no_ready_while_rsp", {30'd0, req0_ready, req1_ready}, 32'd0);
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q[0];
                        check("rsp_latency", cyc, {16'd0, e[22:7]} + 32'd3);
                    end
                end else if (!prev_ready) begin
                    check("rsp_stable", {25'd0, rsp_err, rsp_carry, rsp_data, rsp_id},
                          {25'd0, prev_rsp});
                end
                if (rsp_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_id",    {31'd0, rsp_id},    {31'd0, e[0]});
                    check("rsp_data",  {28'd0, rsp_data},  {28'd0, e[4:1]});
                    check("rsp_carry", {31'd0, rsp_carry}, {31'd0, e[5]});
                    check("rsp_err",   {31'd0, rsp_err},   {31'd0, e[6]});
                    if (e[6]) begin
                        model_fault = 1'b1;
                        if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
                    end
                    check("err_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, model_cnt);
                    check("fault",   {31'd0, fault},   {31'd0, model_fault});
                    check("lanes_equal", {alu_a1, alu_b1, alu_sel2}, {alu_a0, alu_b0, alu_sel1});
                end
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            prev_rsp   = {rsp_err, rsp_carry, rsp_data, rsp_id};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int r, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] s, input logic inj, input logic hold);
        logic ok;
        @(posedge wb_clk_i);
        #1;
        if (r == 0) begin
            req0_a = a; req0_b = b; req0_sel = s; inj0 = inj; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sel = s; inj1 = inj; req1_valid = 1'b1;
        end
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge wb_clk_i);
            if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("issue_timeout", 32'd1, 32'd0);
        @(posedge wb_clk_i);
        #1;
        if (!hold || !ok) begin
            if (r == 0) req0_valid = 1'b0;
            else        req1_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge wb_clk_i);
            if (exp_q.size() == 0 && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_clr();
        @(posedge wb_clk_i);
        #1 fault_clr = 1'b1;
        @(posedge wb_clk_i);
        #1 fault_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err, fault,
                     alu_a0, alu_a1, alu_b0, alu_b1, alu_sel1, alu_sel2},
              32'd0);
        check({name, "_cnt"}, {{(32-CNT_W){1'b0}}, err_cnt}, 32'd0);
        check({name, "_ready"}, {30'd0, req0_ready, req1_ready}, 32'd0);
        check({name, "_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    // response-side ready driver
    initial begin
        forever begin
            @(posedge wb_clk_i);
            #1;
            if (!bp_hold) rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        wb_rst_ni  = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req0_sel = 2'd0;
        req1_a = 4'd0; req1_b = 4'd0; req1_sel = 2'd0;
        inj0 = 1'b0; inj1 = 1'b0; flight_inj = 1'b0;
        fault_clr = 1'b0; rsp_ready = 1'b1;
        rand_ready = 1'b0; bp_hold = 1'b0;
        model_last = 1'b1; model_cnt = 0; model_fault = 1'b0; after_rst = 1'b0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_rsp = 7'd0;

        // reset state, with both requesters asserting valid
        #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_all_zero("reset_outputs");
        repeat (2) @(posedge wb_clk_i);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wb_rst_ni = 1'b1;

        // single add: 9 + 8 = 0x11
        issue(0, 4'h9, 4'h8, 2'd0, 1'b0, 1'b0);
        wait_drain();

        // fairness with both held valid
        fork
            for (int i = 0; i < 3; i++)
                issue(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), 1'b0, i < 2);
            for (int i = 0; i < 3; i++)
                issue(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), 1'b0, i < 2);
        join
        wait_drain();

        // backpressure: response held 5 cycles, other requester waiting
        @(posedge wb_clk_i);
        #1;
        bp_hold = 1'b1; rsp_ready = 1'b0;
        fork
            issue(0, 4'h3, 4'h7, 2'd1, 1'b0, 1'b0);
            issue(1, 4'hc, 4'h5, 2'd3, 1'b0, 1'b0);
            begin
                logic seen;
                seen = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    @(negedge wb_clk_i);
                    if (rsp_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("bp_rsp_seen", {31'd0, seen}, 32'd1);
                repeat (5) @(posedge wb_clk_i);
                #1;
                rsp_ready = 1'b1; bp_hold = 1'b0;
            end
        join
        wait_drain();

        // lane fault, then a clean op
        issue(0, 4'h5, 4'h6, 2'd0, 1'b1, 1'b0);
        wait_drain();
        check("lane_fault_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd1);
        check("lane_fault_flag", {31'd0, fault}, 32'd1);
        issue(1, 4'ha, 4'h3, 2'd2, 1'b0, 1'b0);
        wait_drain();
        check("clean_keeps_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd1);
        check("clean_keeps_flag", {31'd0, fault}, 32'd1);

        // saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            issue(i % 2, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 1'b1, 1'b0);
            wait_drain();
        end
        check("sat_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd3);

        // clear alone
        pulse_clr();
        model_cnt = 0; model_fault = 1'b0;
        #1;
        check("clr_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd0);
        check("clr_flag", {31'd0, fault}, 32'd0);

        // saturate again, then clear coinciding with an erroneous capture
        for (int i = 0; i < 3; i++) begin
            issue(0, 4'h1, 4'h2, 2'd0, 1'b1, 1'b0);
            wait_drain();
        end
        issue(0, 4'h4, 4'h4, 2'd3, 1'b1, 1'b0);  // returns in cycle T+1
        @(posedge wb_clk_i);                     // cycle T+2: capture cycle
        #1 fault_clr = 1'b1;
        model_cnt = 0;                           // capture after clear counts 1
        @(posedge wb_clk_i);
        #1 fault_clr = 1'b0;
        wait_drain();
        check("clr_vs_err_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd1);
        check("clr_vs_err_flag", {31'd0, fault}, 32'd1);

        // reset in the middle of WAIT
        issue(1, 4'h7, 4'h7, 2'd0, 1'b0, 1'b0);  // returns in cycle T+1
        #2;
        wb_rst_ni = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_all_zero("mid_wait_reset");
        exp_q.delete();
        model_last = 1'b1; model_cnt = 0; model_fault = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge wb_clk_i);
        #1;
        wb_rst_ni = 1'b1;
        after_rst = 1'b1;
        fork
            issue(0, 4'h2, 4'h9, 2'd1, 1'b0, 1'b0);
            issue(1, 4'hf, 4'h1, 2'd0, 1'b0, 1'b0);
        join
        wait_drain();
        check("first_grant_seen", {31'd0, after_rst}, 32'd0);

        // randomized traffic with random response backpressure
        rand_ready = 1'b1;
        fork
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge wb_clk_i);
                issue(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 1) == 1) && (i < 14));
            end
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge wb_clk_i);
                issue(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 1) == 1) && (i < 14));
            end
        join
        rand_ready = 1'b0;
        wait_drain();
        check("queue_empty_at_end", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
